id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register with operand forwarding. It sits directly upstream of the ALU.
- Captures decoded operands, ALU function code and destination info from the decode stage.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Presents registered op1/op2/fn to the ALU one cycle later. Supports stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_operand_stage.sv | 113 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Resolves RAW hazards by forwarding
// from EX/MEM and MEM/WB. Supports stall (hold) and flush (bubble).
module id_ex_operand_stage #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3,
   parameter int FN_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_op1,
   input  logic [DATA_W-1:0] id_op2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [FN_W-1:0]   id_fn,
   input  logic              id_wr_en,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_wr_en,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_wr_en,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [FN_W-1:0]   ex_fn,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_wr_en,
   output logic [7:0]        fwd_count
);

   logic              hit1_ex, hit1_wb, hit2_ex, hit2_wb;
   logic              fwd1, fwd2;
   logic [DATA_W-1:0] op1_p0, op2_p0;
   logic [1:0]        fwd_n;
   logic [7:0]        cnt_next;

   logic              vld_p1, wr_en_p1;
   logic [DATA_W-1:0] op1_p1, op2_p1;
   logic [FN_W-1:0]   fn_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [7:0]        cnt_p1;

   function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'd0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // stage p0: forwarding select (r0 is hardwired zero, never forwarded)
   always_comb begin
      hit1_ex = exmem_wr_en && (exmem_rd == id_rs1) && (id_rs1 != '0);
      hit1_wb = memwb_wr_en && (memwb_rd == id_rs1) && (id_rs1 != '0);
      hit2_ex = exmem_wr_en && (exmem_rd == id_rs2) && (id_rs2 != '0);
      hit2_wb = memwb_wr_en && (memwb_rd == id_rs2) && (id_rs2 != '0);
      fwd1    = hit1_ex || hit1_wb;
      fwd2    = !id_use_imm && (hit2_ex || hit2_wb);

      op1_p0 = id_op1;
      if (hit1_ex)      op1_p0 = exmem_data;
      else if (hit1_wb) op1_p0 = memwb_data;

      op2_p0 = id_op2;
      if (id_use_imm)   op2_p0 = id_imm;
      else if (hit2_ex) op2_p0 = exmem_data;
      else if (hit2_wb) op2_p0 = memwb_data;

      fwd_n    = {1'b0, fwd1} + {1'b0, fwd2};
      cnt_next = sat_add(cnt_p1, fwd_n);
   end

   // stage p1: ID/EX register, priority flush > stall > capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         wr_en_p1 <= 1'b0;
         op1_p1   <= '0;
         op2_p1   <= '0;
         fn_p1    <= '0;
         rd_p1    <= '0;
         cnt_p1   <= '0;
      end else if (flush) begin
         vld_p1   <= 1'b0;
         wr_en_p1 <= 1'b0;
         op1_p1   <= '0;
         op2_p1   <= '0;
         fn_p1    <= '0;
         rd_p1    <= '0;
      end else if (!stall) begin
         vld_p1   <= id_valid;
         wr_en_p1 <= id_valid & id_wr_en;
         op1_p1   <= id_valid ? op1_p0 : '0;
         op2_p1   <= id_valid ? op2_p0 : '0;
         fn_p1    <= id_valid ? id_fn  : '0;
         rd_p1    <= id_valid ? id_rd  : '0;
         if (id_valid) cnt_p1 <= cnt_next;
      end
   end

   assign ex_valid  = vld_p1;
   assign ex_wr_en  = wr_en_p1;
   assign ex_op1    = op1_p1;
   assign ex_op2    = op2_p1;
   assign ex_fn     = fn_p1;
   assign ex_rd     = rd_p1;
   assign fwd_count = cnt_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_id_ex_operand_stage;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 0, id_use_imm = 0, id_wr_en = 0, stall = 0, flush = 0;
   logic [2:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
   logic [7:0] id_op1 = 0, id_op2 = 0, id_imm = 0, exmem_data = 0, memwb_data = 0;
   logic [1:0] id_fn = 0;
   logic       exmem_wr_en = 0, memwb_wr_en = 0;
   logic       ex_valid, ex_wr_en;
   logic [7:0] ex_op1, ex_op2, fwd_count;
   logic [1:0] ex_fn;
   logic [2:0] ex_rd;

   int errors = 0;
   int checks = 0;

   id_ex_operand_stage #(.DATA_W(8), .REG_AW(3), .FN_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm), .id_use_imm(id_use_imm),
      .id_fn(id_fn), .id_wr_en(id_wr_en), .stall(stall), .flush(flush),
      .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_fn(ex_fn),
      .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .fwd_count(fwd_count)
   );

   always #5 clk = ~clk;

   // behavioural model of the stage contents
   int m_valid = 0, m_wr = 0, m_op1 = 0, m_op2 = 0, m_fn = 0, m_rd = 0, m_cnt = 0;

   function automatic int source_value(int s, int rf_val, output int hit);
      hit = 1;
      if (s != 0 && exmem_wr_en && exmem_rd == s) return exmem_data;
      if (s != 0 && memwb_wr_en && memwb_rd == s) return memwb_data;
      hit = 0;
      return rf_val;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int h1, h2, v1, v2;
      if (!rst_n) begin
         m_valid = 0; m_wr = 0; m_op1 = 0; m_op2 = 0; m_fn = 0; m_rd = 0; m_cnt = 0;
      end else if (flush) begin
         m_valid = 0; m_wr = 0; m_op1 = 0; m_op2 = 0; m_fn = 0; m_rd = 0;
      end else if (!stall) begin
         if (id_valid) begin
            v1 = source_value(id_rs1, id_op1, h1);
            if (id_use_imm) begin
               v2 = id_imm;
               h2 = 0;
            end else begin
               v2 = source_value(id_rs2, id_op2, h2);
            end
            m_valid = 1; m_wr = id_wr_en; m_op1 = v1; m_op2 = v2;
            m_fn = id_fn; m_rd = id_rd;
            m_cnt = (m_cnt + h1 + h2 > 255) ? 255 : m_cnt + h1 + h2;
         end else begin
            m_valid = 0; m_wr = 0; m_op1 = 0; m_op2 = 0; m_fn = 0; m_rd = 0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cmp_valid", ex_valid, m_valid);
      check("cmp_wr_en", ex_wr_en, m_wr);
      check("cmp_op1", ex_op1, m_op1);
      check("cmp_op2", ex_op2, m_op2);
      check("cmp_fn", ex_fn, m_fn);
      check("cmp_rd", ex_rd, m_rd);
      check("cmp_fwd_count", fwd_count, m_cnt);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                         input int op1, input int op2, input int imm, input logic use_imm,
                         input int fn, input logic wr);
      id_valid = v; id_rs1 = 3'(rs1); id_rs2 = 3'(rs2); id_rd = 3'(rd);
      id_op1 = 8'(op1); id_op2 = 8'(op2); id_imm = 8'(imm); id_use_imm = use_imm;
      id_fn = 2'(fn); id_wr_en = wr;
   endtask

   task automatic set_fwd(input logic xw, input int xrd, input int xd,
                          input logic ww, input int wrd, input int wd);
      exmem_wr_en = xw; exmem_rd = 3'(xrd); exmem_data = 8'(xd);
      memwb_wr_en = ww; memwb_rd = 3'(wrd); memwb_data = 8'(wd);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, ex_valid, 0);
      check({tag, "_wr_en"}, ex_wr_en, 0);
      check({tag, "_op1"}, ex_op1, 0);
      check({tag, "_op2"}, ex_op2, 0);
      check({tag, "_fn"}, ex_fn, 0);
      check({tag, "_rd"}, ex_rd, 0);
      check({tag, "_cnt"}, fwd_count, 0);
   endtask

   initial begin
      // reset with random inputs
      for (int i = 0; i < 3; i++) begin
         set_id(1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, 1'($urandom), $urandom, 1'($urandom));
         set_fwd(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom);
         step();
      end
      check_all_zero("reset");
      set_fwd(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      set_id(1, 1, 2, 3, 2, 4, 0, 0, 1, 1);
      step();
      check("first_op1", ex_op1, 2);
      check("first_op2", ex_op2, 4);
      check("first_fn", ex_fn, 1);
      check("first_rd", ex_rd, 3);
      check("first_valid", ex_valid, 1);
      check("first_wr_en", ex_wr_en, 1);

      // forwarding priority
      set_id(1, 2, 5, 1, 5, 0, 0, 0, 0, 1);
      set_fwd(1, 2, 9, 1, 2, 7);
      step();
      check("fwd_exmem_op1", ex_op1, 9);
      check("fwd_exmem_cnt", fwd_count, 1);
      set_fwd(0, 2, 9, 1, 2, 7);
      step();
      check("fwd_memwb_op1", ex_op1, 7);
      check("fwd_memwb_cnt", fwd_count, 2);

      // r0 never forwarded; immediate bypasses rs2 forwarding
      set_id(1, 0, 5, 1, 0, 6, 0, 0, 0, 1);
      set_fwd(1, 0, 8'hFF, 0, 0, 0);
      step();
      check("r0_op1", ex_op1, 0);
      check("r0_cnt", fwd_count, 2);
      set_id(1, 1, 4, 1, 8, 6, 3, 1, 0, 1);
      set_fwd(1, 4, 8'hAA, 0, 0, 0);
      step();
      check("imm_op2", ex_op2, 3);
      check("imm_op1", ex_op1, 8);
      check("imm_cnt", fwd_count, 2);

      // stall holds, then flush beats stall
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 1, 2, 5, 5, 3, 0, 0, 2, 1);
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 1, 2, 6, 20 + i, 30 + i, 0, 0, 1, 1);
         set_fwd(1, 1, 40 + i, 1, 2, 50 + i);
         step();
      end
      check("stall_op1", ex_op1, 5);
      check("stall_op2", ex_op2, 3);
      check("stall_fn", ex_fn, 2);
      check("stall_cnt", fwd_count, 2);
      flush = 1'b1;
      step();
      check("flush_valid", ex_valid, 0);
      check("flush_wr_en", ex_wr_en, 0);
      check("flush_op1", ex_op1, 0);
      check("flush_op2", ex_op2, 0);
      check("flush_cnt", fwd_count, 2);
      stall = 1'b0;
      flush = 1'b0;

      // bubble
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(0, 1, 2, 4, 1, 3, 0, 0, 3, 1);
      step();
      check("bubble_valid", ex_valid, 0);
      check("bubble_wr_en", ex_wr_en, 0);
      check("bubble_op1", ex_op1, 0);
      check("bubble_op2", ex_op2, 0);
      check("bubble_fn", ex_fn, 0);

      // saturation: 2 + 130*2 > 255
      set_id(1, 1, 2, 3, 0, 0, 0, 0, 1, 1);
      set_fwd(1, 1, 11, 1, 2, 22);
      for (int i = 0; i < 130; i++) step();
      check("sat_cnt", fwd_count, 255);
      check("sat_op1", ex_op1, 11);
      check("sat_op2", ex_op2, 22);
      step();
      check("sat_hold", fwd_count, 255);

      // asynchronous reset mid-cycle, including while stalled
      stall = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      step();
      stall = 1'b0;
      rst_n = 1'b1;
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 3, 4, 2, 7, 9, 0, 0, 3, 0);
      step();
      check("post_rst_op1", ex_op1, 7);
      check("post_rst_wr_en", ex_wr_en, 0);
      check("post_rst_cnt", fwd_count, 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
